// File: rtl/boss_hp_ctrl_pkg.sv
// Shared game definitions: boss FSM encoding, health/phase thresholds and hitbox size.
// The boss movement block imports this too, so phase thresholds stay in one place.
package boss_hp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIGHT,
    ST_COOLDOWN,
    ST_GRACE,
    ST_DEAD
  } boss_state_t;

  localparam int HP_W  = 10;
  localparam int CNT_W = 5;

  localparam logic [HP_W-1:0] HP_MAX  = 10'd450;
  localparam logic [HP_W-1:0] DMG     = 10'd10;
  localparam logic [HP_W-1:0] PH2_TOP = 10'd300;
  localparam logic [HP_W-1:0] PH3_TOP = 10'd150;

  localparam logic [9:0] BOSS_W = 10'd160;
  localparam logic [9:0] BOSS_H = 10'd120;

  // Counter reload values: invulnerability lasts exactly HIT_CD / PHASE_GRACE cycles.
  localparam int HIT_CD      = 8;
  localparam int PHASE_GRACE = 32;
  localparam logic [CNT_W-1:0] HIT_CD_LOAD = CNT_W'(HIT_CD - 1);
  localparam logic [CNT_W-1:0] GRACE_LOAD  = CNT_W'(PHASE_GRACE - 1);

  function automatic logic [1:0] hp_phase(input logic [HP_W-1:0] hp);
    if (hp == '0)          return 2'd0;
    else if (hp <= PH3_TOP) return 2'd3;
    else if (hp <= PH2_TOP) return 2'd2;
    else                    return 2'd1;
  endfunction

endpackage

// File: rtl/hitbox_cmp.sv
// Combinational point-in-rectangle test; rectangle spans [x, x+W) by [y, y+H).
// Right/bottom edges are formed in 11 bits so a box near the screen edge never wraps.
module hitbox_cmp #(
  parameter logic [9:0] W = 10'd160,
  parameter logic [9:0] H = 10'd120
) (
  input  logic       pt_valid,
  input  logic [9:0] pt_x,
  input  logic [9:0] pt_y,
  input  logic [9:0] rect_x,
  input  logic [9:0] rect_y,
  output logic       hit
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_x;
  logic        in_y;

  assign x_end = {1'b0, rect_x} + {1'b0, W};
  assign y_end = {1'b0, rect_y} + {1'b0, H};

  assign in_x = (pt_x >= rect_x) && ({1'b0, pt_x} < x_end);
  assign in_y = (pt_y >= rect_y) && ({1'b0, pt_y} < y_end);

  assign hit = pt_valid && in_x && in_y;

endmodule

// File: rtl/boss_hp_ctrl.sv
// Boss health controller: bullet hit detection, damage with cooldown, phase grace
// periods and sticky defeat. All outputs are registered.
import boss_hp_ctrl_pkg::*;

module boss_hp_ctrl (
  input  logic            clk22,
  input  logic            rst,
  input  logic            gamestart,
  input  logic            boss,
  input  logic [9:0]      bossx,
  input  logic [9:0]      bossy,
  input  logic            bullet_valid,
  input  logic [9:0]      bullet_x,
  input  logic [9:0]      bullet_y,
  output logic [HP_W-1:0] bosshp,
  output logic            bullet_hit,
  output logic            flash,
  output logic [1:0]      phase,
  output logic            boss_dead
);

  boss_state_t      state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             flash_q, flash_d;
  logic [1:0]       phase_q, phase_d;
  logic             dead_q, dead_d;

  logic             overlap;
  logic [HP_W-1:0]  hp_after_hit;

  hitbox_cmp #(
    .W (BOSS_W),
    .H (BOSS_H)
  ) u_hitbox (
    .pt_valid (bullet_valid),
    .pt_x     (bullet_x),
    .pt_y     (bullet_y),
    .rect_x   (bossx),
    .rect_y   (bossy),
    .hit      (overlap)
  );

  assign hp_after_hit = (hp_q <= DMG) ? '0 : hp_q - DMG;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (boss && (hp_q != '0)) state_d = ST_FIGHT;
      end
      ST_FIGHT: begin
        if (!boss) begin
          state_d = ST_IDLE;
        end else if (overlap) begin
          hit_d = 1'b1;
          hp_d  = hp_after_hit;
          if (hp_after_hit == '0) begin
            state_d = ST_DEAD;
          end else if (hp_phase(hp_after_hit) != hp_phase(hp_q)) begin
            state_d = ST_GRACE;
            cnt_d   = GRACE_LOAD;
          end else begin
            state_d = ST_COOLDOWN;
            cnt_d   = HIT_CD_LOAD;
          end
        end
      end
      ST_COOLDOWN, ST_GRACE: begin
        if (!boss) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_FIGHT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DEAD: begin
        hp_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status outputs track the next state so they line up with the hp update.
    flash_d = (state_d == ST_COOLDOWN);
    dead_d  = (state_d == ST_DEAD);
    phase_d = ((state_d == ST_IDLE) || (state_d == ST_DEAD)) ? 2'd0 : hp_phase(hp_d);
  end

  always_ff @(posedge clk22) begin
    if (rst || gamestart) begin
      state_q <= ST_IDLE;
      hp_q    <= HP_MAX;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      flash_q <= 1'b0;
      phase_q <= 2'd0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      flash_q <= flash_d;
      phase_q <= phase_d;
      dead_q  <= dead_d;
    end
  end

  assign bosshp     = hp_q;
  assign bullet_hit = hit_q;
  assign flash      = flash_q;
  assign phase      = phase_q;
  assign boss_dead  = dead_q;

endmodule

// File: tb/tb_boss_hp_ctrl.sv
// Directed bench for boss_hp_ctrl: each step queues its expected outputs and
// checks them one clock later with immediate assertions.
module tb_boss_hp_ctrl;

  localparam logic [9:0] HX = 10'd105;
  localparam logic [9:0] HY = 10'd80;

  logic       clk22 = 1'b0;
  logic       rst, gamestart, boss, bullet_valid;
  logic [9:0] bossx, bossy, bullet_x, bullet_y;
  logic [9:0] bosshp;
  logic       bullet_hit, flash, boss_dead;
  logic [1:0] phase;

  typedef struct packed {
    logic [9:0] hp;
    logic       hit;
    logic       fl;
    logic [1:0] ph;
    logic       dead;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    hp;

  always #5 clk22 = ~clk22;

  boss_hp_ctrl dut (
    .clk22        (clk22),
    .rst          (rst),
    .gamestart    (gamestart),
    .boss         (boss),
    .bossx        (bossx),
    .bossy        (bossy),
    .bullet_valid (bullet_valid),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bosshp       (bosshp),
    .bullet_hit   (bullet_hit),
    .flash        (flash),
    .phase        (phase),
    .boss_dead    (boss_dead)
  );

  function automatic logic [1:0] ph_of(input int h);
    if (h > 300) return 2'd1;
    if (h > 150) return 2'd2;
    if (h > 0)   return 2'd3;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [9:0] obs, input logic [9:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic b, input logic v,
                      input logic [9:0] x, input logic [9:0] y,
                      input int e_hp, input logic e_hit, input logic e_fl,
                      input logic [1:0] e_ph, input logic e_dead, input string tag);
    exp_t  e;
    string t;
    rst = r; gamestart = g; boss = b;
    bullet_valid = v; bullet_x = x; bullet_y = y;
    e.hp = 10'(e_hp); e.hit = e_hit; e.fl = e_fl; e.ph = e_ph; e.dead = e_dead;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk22);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    $display("[%0t] %s hp=%0d hit=%0d flash=%0d phase=%0d dead=%0d",
             $time, t, bosshp, bullet_hit, flash, phase, boss_dead);
    chk({t, ".hp"},    bosshp,            e.hp);
    chk({t, ".hit"},   {9'd0, bullet_hit}, {9'd0, e.hit});
    chk({t, ".flash"}, {9'd0, flash},      {9'd0, e.fl});
    chk({t, ".phase"}, {8'd0, phase},      {8'd0, e.ph});
    chk({t, ".dead"},  {9'd0, boss_dead},  {9'd0, e.dead});
  endtask

  // Seven more flashing cycles after the hit cycle, then back to FIGHT.
  task automatic cool(input int h);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0, h, 0, 1, ph_of(h), 0, "cooldown");
    step(0, 0, 1, 0, 0, 0, h, 0, 0, ph_of(h), 0, "cd_end");
  endtask

  // Bullet held on the boss for the whole grace window: no damage may land.
  task automatic grace(input int h);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 1, HX, HY, h, 0, 0, ph_of(h), 0, "grace");
  endtask

  task automatic hit_once(inout int h);
    int nhp;
    nhp = (h <= 10) ? 0 : h - 10;
    if (nhp == 0) begin
      step(0, 0, 1, 1, HX, HY, 0, 1, 0, 2'd0, 1, "kill");
    end else if (ph_of(nhp) != ph_of(h)) begin
      step(0, 0, 1, 1, HX, HY, nhp, 1, 0, ph_of(nhp), 0, "phase_hit");
      grace(nhp);
    end else begin
      step(0, 0, 1, 1, HX, HY, nhp, 1, 1, ph_of(nhp), 0, "hit");
      cool(nhp);
    end
    h = nhp;
  endtask

  initial begin
    bossx = 10'd100;
    bossy = 10'd75;

    step(1, 0, 0, 0, 0, 0, 450, 0, 0, 0, 0, "reset0");
    step(1, 0, 0, 0, 0, 0, 450, 0, 0, 0, 0, "reset1");
    step(0, 0, 0, 1, HX, HY, 450, 0, 0, 0, 0, "idle_ignore");
    step(0, 0, 1, 0, 0, 0, 450, 0, 0, 1, 0, "enter_fight");

    step(0, 0, 1, 1, HX, HY, 440, 1, 1, 1, 0, "hit1");
    step(0, 0, 1, 0, 0, 0, 440, 0, 1, 1, 0, "pulse_end");
    step(0, 0, 1, 0, 0, 0, 440, 0, 1, 1, 0, "cooldown");
    step(0, 0, 1, 1, HX, HY, 440, 0, 1, 1, 0, "cd_immune");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 440, 0, 1, 1, 0, "cooldown");
    step(0, 0, 1, 0, 0, 0, 440, 0, 0, 1, 0, "cd_end");

    step(0, 0, 1, 1, 10'd260, 10'd80, 440, 0, 0, 1, 0, "x_edge_miss");
    step(0, 0, 1, 1, 10'd99,  10'd80, 440, 0, 0, 1, 0, "x_low_miss");
    step(0, 0, 1, 1, 10'd105, 10'd74, 440, 0, 0, 1, 0, "y_low_miss");
    step(0, 0, 1, 0, HX, HY,          440, 0, 0, 1, 0, "invalid_miss");
    step(0, 0, 1, 1, 10'd259, 10'd194, 430, 1, 1, 1, 0, "corner_hit");
    cool(430);
    step(0, 0, 1, 1, 10'd259, 10'd195, 430, 0, 0, 1, 0, "y_edge_miss");
    step(0, 0, 1, 1, 10'd100, 10'd75,  420, 1, 1, 1, 0, "origin_hit");
    cool(420);

    hp = 420;
    while (hp > 0) hit_once(hp);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, HX, HY, 0, 0, 0, 0, 1, "dead_hold");
    step(0, 0, 0, 1, HX, HY, 0, 0, 0, 0, 1, "dead_noboss");

    step(0, 1, 1, 0, 0, 0, 450, 0, 0, 0, 0, "gamestart");
    step(0, 0, 1, 0, 0, 0, 450, 0, 0, 1, 0, "refight");
    step(0, 0, 1, 1, HX, HY, 440, 1, 1, 1, 0, "hit_again");
    step(0, 0, 1, 0, 0, 0, 440, 0, 1, 1, 0, "cooldown");
    step(0, 1, 1, 1, HX, HY, 450, 0, 0, 0, 0, "gs_beats_hit");
    step(0, 0, 1, 1, HX, HY, 450, 0, 0, 1, 0, "idle_to_fight");
    step(0, 0, 1, 1, HX, HY, 440, 1, 1, 1, 0, "first_fight_hit");
    cool(440);
    step(0, 0, 0, 0, 0, 0, 440, 0, 0, 0, 0, "boss_drop");
    step(0, 0, 1, 0, 0, 0, 440, 0, 0, 1, 0, "boss_back");
    step(0, 0, 1, 1, HX, HY, 430, 1, 1, 1, 0, "hit_then_drop");
    step(0, 0, 0, 1, HX, HY, 430, 0, 0, 0, 0, "drop_in_cd");
    step(0, 0, 1, 1, HX, HY, 430, 0, 0, 1, 0, "return_fight");
    step(0, 0, 1, 1, HX, HY, 420, 1, 1, 1, 0, "hit_after_return");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
